// File: rtl/crc_frame_feeder.sv
// Word-to-serial feeder for the serial CRC block: serializes one accepted word per
// frame, drains the CRC read-out with ACTIVE low, then pulses the CRC block's clear.
module crc_frame_feeder #(
    parameter int DATA_WD   = 8,
    parameter int LFSR_WD   = 8,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic [DATA_WD-1:0] IN_DATA,
    input  logic               IN_VALID,
    output logic               IN_READY,
    output logic               DATA,
    output logic               ACTIVE,
    output logic               CRC_RST_N,
    output logic               BUSY,
    output logic               FRAME_DONE
);

    // One counter serves both the bit count (0..DATA_WD-1) and the drain count (0..LFSR_WD).
    localparam int CNT_MAX = (DATA_WD > LFSR_WD + 1) ? DATA_WD : LFSR_WD + 1;
    localparam int CNT_WD  = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_WD-1:0] LAST_BIT   = CNT_WD'(DATA_WD - 1);
    localparam logic [CNT_WD-1:0] LAST_DRAIN = CNT_WD'(LFSR_WD);
    localparam logic [CNT_WD-1:0] CNT_ZERO   = CNT_WD'(0);
    localparam logic [CNT_WD-1:0] CNT_ONE    = CNT_WD'(1);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    state_t             state_r;
    logic [DATA_WD-1:0] shift_r;
    logic [DATA_WD-1:0] shift_next_s;
    logic [CNT_WD-1:0]  cnt_r;
    logic               data_r;
    logic               active_r;
    logic               crc_rst_n_r;
    logic               frame_done_r;

    function automatic logic [DATA_WD-1:0] advance_word(input logic [DATA_WD-1:0] word);
        logic [DATA_WD-1:0] res;
        if (MSB_FIRST) begin
            res = word << 1;
        end else begin
            res = word >> 1;
        end
        return res;
    endfunction

    function automatic logic head_bit(input logic [DATA_WD-1:0] word);
        logic res;
        if (MSB_FIRST) begin
            res = word[DATA_WD-1];
        end else begin
            res = word[0];
        end
        return res;
    endfunction

    // Word as it looks after the currently presented bit has been consumed.
    always_comb begin
        shift_next_s = advance_word(shift_r);
    end

    // Frame sequencer: accept, serialize, drain, clear.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r      <= ST_CLEAR;
            shift_r      <= {DATA_WD{1'b0}};
            cnt_r        <= CNT_ZERO;
            data_r       <= 1'b0;
            active_r     <= 1'b0;
            crc_rst_n_r  <= 1'b0;
            frame_done_r <= 1'b0;
        end else begin
            frame_done_r <= 1'b0;
            case (state_r)
                ST_CLEAR: begin
                    crc_rst_n_r <= 1'b1;
                    state_r     <= ST_IDLE;
                end
                ST_IDLE: begin
                    if (IN_VALID) begin
                        shift_r  <= IN_DATA;
                        data_r   <= head_bit(IN_DATA);
                        active_r <= 1'b1;
                        cnt_r    <= CNT_ZERO;
                        state_r  <= ST_SHIFT;
                    end else begin
                        state_r  <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    if (cnt_r == LAST_BIT) begin
                        active_r <= 1'b0;
                        data_r   <= 1'b0;
                        cnt_r    <= CNT_ZERO;
                        state_r  <= ST_DRAIN;
                    end else begin
                        shift_r  <= shift_next_s;
                        data_r   <= head_bit(shift_next_s);
                        cnt_r    <= cnt_r + CNT_ONE;
                    end
                end
                ST_DRAIN: begin
                    // Extra drain cycle keeps the last CRC bit visible before the clear.
                    if (cnt_r == LAST_DRAIN) begin
                        cnt_r        <= CNT_ZERO;
                        crc_rst_n_r  <= 1'b0;
                        frame_done_r <= 1'b1;
                        state_r      <= ST_CLEAR;
                    end else begin
                        cnt_r        <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_r     <= ST_CLEAR;
                    cnt_r       <= CNT_ZERO;
                    data_r      <= 1'b0;
                    active_r    <= 1'b0;
                    crc_rst_n_r <= 1'b0;
                end
            endcase
        end
    end

    assign IN_READY   = (state_r == ST_IDLE);
    assign BUSY       = (state_r != ST_IDLE);
    assign DATA       = data_r;
    assign ACTIVE     = active_r;
    assign CRC_RST_N  = crc_rst_n_r;
    assign FRAME_DONE = frame_done_r;

endmodule
